rob_id_alloc: RTL and testbench

//  Allocation and retirement side of the read reorder buffer in the AXI interconnect.

---
 rtl/rob_id_alloc.sv | 101 ++++++++++
 tb/tb_rob_id_alloc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rob_id_alloc.sv
// Age-ordered ID table for the read reorder buffer: AR pushes append, final R beats
// retire the oldest matching ID and compact the table toward entry 0.
module rob_id_alloc #(
  parameter int              DEPTH      = 4,
  parameter int              ID_W       = 8,
  parameter logic [ID_W-1:0] INVALID_ID = '1,
  localparam int             CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       ar_id,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ID_W-1:0]       r_id,
  input  logic                  r_valid,
  input  logic                  r_ready,
  input  logic                  r_last,
  output logic [DEPTH*ID_W-1:0] rob_buffer,
  output logic [DEPTH-1:0]      rob_valid,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  retire_err,
  output logic                  alloc_err
);

  logic [ID_W-1:0] entries     [DEPTH];
  logic [ID_W-1:0] entries_nxt [DEPTH];
  logic [DEPTH-1:0] valid_nxt;
  logic [CW-1:0]   count_base;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   match_idx;
  logic            found;
  logic            retire_req;
  logic            pop;
  logic            push;
  logic            alloc_bad;

  // Descending scan so the lowest (oldest) matching index is the one that sticks.
  always_comb begin
    found     = 1'b0;
    match_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rob_valid[i] && (entries[i] == r_id)) begin
        found     = 1'b1;
        match_idx = CW'(i);
      end
    end
  end

  assign ar_ready   = !full;
  assign retire_req = r_valid && r_ready && r_last;
  assign pop        = retire_req && found;
  assign push       = ar_valid && ar_ready && (ar_id != INVALID_ID);
  assign alloc_bad  = ar_valid && ar_ready && (ar_id == INVALID_ID);

  // Compaction happens first so a simultaneous push lands in the freshly vacated tail slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries_nxt[i] = entries[i];
    count_base = count;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (CW'(i) >= match_idx) entries_nxt[i] = entries[i+1];
      end
      entries_nxt[DEPTH-1] = INVALID_ID;
      count_base           = count - 1'b1;
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_base) entries_nxt[i] = ar_id;
      end
    end
    count_nxt = count_base + {{(CW-1){1'b0}}, push};
    for (int i = 0; i < DEPTH; i++) valid_nxt[i] = (CW'(i) < count_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= INVALID_ID;
      rob_valid  <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      retire_err <= 1'b0;
      alloc_err  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= entries_nxt[i];
      rob_valid  <= valid_nxt;
      count      <= count_nxt;
      full       <= (count_nxt == CW'(DEPTH));
      empty      <= (count_nxt == '0);
      retire_err <= retire_req && !found;
      alloc_err  <= alloc_bad;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_buf
    assign rob_buffer[g*ID_W +: ID_W] = entries[g];
  end

endmodule

// File: tb/tb_rob_id_alloc.sv
// Bench for rob_id_alloc: directed scenarios plus random traffic, checked against a
// queue-based reference table through an expected-snapshot scoreboard.
module tb_rob_id_alloc;
  localparam int DEPTH = 4;
  localparam int ID_W  = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [ID_W-1:0] INV = 8'hFF;
  localparam int EW = DEPTH*ID_W + DEPTH + CW + 5;

  logic                  clk, rst;
  logic [ID_W-1:0]       ar_id, r_id;
  logic                  ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [DEPTH*ID_W-1:0] rob_buffer;
  logic [DEPTH-1:0]      rob_valid;
  logic [CW-1:0]         count;
  logic                  full, empty, retire_err, alloc_err;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0]   exp_q[$];
  logic [ID_W-1:0] mq[$];  // reference table, oldest first

  rob_id_alloc #(.DEPTH(DEPTH), .ID_W(ID_W), .INVALID_ID(INV)) dut (
    .clk(clk), .rst(rst),
    .ar_id(ar_id), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .rob_buffer(rob_buffer), .rob_valid(rob_valid), .count(count),
    .full(full), .empty(empty), .retire_err(retire_err), .alloc_err(alloc_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] snapshot(input bit rerr, input bit aerr);
    logic [DEPTH*ID_W-1:0] b;
    logic [DEPTH-1:0]      v;
    int n;
    n = mq.size();
    for (int i = 0; i < DEPTH; i++) begin
      b[i*ID_W +: ID_W] = (i < n) ? mq[i] : INV;
      v[i]              = (i < n);
    end
    return {b, v, CW'(n), n == DEPTH, n == 0, rerr, aerr, n < DEPTH};
  endfunction

  // driver: apply one cycle of inputs, advance the reference table, queue the expected result
  task automatic drive(input bit av, input logic [ID_W-1:0] aid, input bit rv, input bit rr,
                       input bit rl, input logic [ID_W-1:0] rid);
    bit rerr, aerr, rdy;
    int hit;
    rerr = 0; aerr = 0; hit = -1;
    ar_valid = av; ar_id = aid; r_valid = rv; r_ready = rr; r_last = rl; r_id = rid;
    rdy = (mq.size() < DEPTH);
    if (rv && rr && rl) begin
      foreach (mq[i]) if (hit < 0 && mq[i] == rid) hit = i;
      if (hit >= 0) mq.delete(hit);
      else rerr = 1;
    end
    if (av && rdy) begin
      if (aid == INV) aerr = 1;
      else mq.push_back(aid);
    end
    @(posedge clk);
    exp_q.push_back(snapshot(rerr, aerr));
    #1;
  endtask

  task automatic idle();
    drive(0, 8'h00, 0, 0, 0, 8'h00);
  endtask

  // monitor: pop one expected snapshot per clocked result
  always @(negedge clk) begin
    logic [DEPTH*ID_W-1:0] eb;
    logic [DEPTH-1:0]      ev;
    logic [CW-1:0]         ec;
    logic ef, ee, ere, eae, ear;
    if (!rst && exp_q.size() > 0) begin
      {eb, ev, ec, ef, ee, ere, eae, ear} = exp_q.pop_front();
      check("rob_buffer", 64'(rob_buffer), 64'(eb));
      check("rob_valid",  64'(rob_valid),  64'(ev));
      check("count",      64'(count),      64'(ec));
      check("full",       64'(full),       64'(ef));
      check("empty",      64'(empty),      64'(ee));
      check("retire_err", 64'(retire_err), 64'(ere));
      check("alloc_err",  64'(alloc_err),  64'(eae));
      check("ar_ready",   64'(ar_ready),   64'(ear));
    end
  end

  function automatic logic [ID_W-1:0] pick_id();
    logic [ID_W-1:0] pool [5];
    pool[0] = 8'h10; pool[1] = 8'h21; pool[2] = 8'h32; pool[3] = 8'h43; pool[4] = 8'h54;
    if ($urandom_range(0, 9) == 0) return INV;
    return pool[$urandom_range(0, 4)];
  endfunction

  initial begin
    logic [ID_W-1:0] rid;
    rst = 1'b1;
    ar_valid = 0; ar_id = '0; r_valid = 0; r_ready = 0; r_last = 0; r_id = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_count",      64'(count),      64'd0);
    check("rst_empty",      64'(empty),      64'd1);
    check("rst_full",       64'(full),       64'd0);
    check("rst_ar_ready",   64'(ar_ready),   64'd1);
    check("rst_buffer",     64'(rob_buffer), 64'hFFFF_FFFF);
    check("rst_valid",      64'(rob_valid),  64'd0);
    check("rst_retire_err", 64'(retire_err), 64'd0);
    check("rst_alloc_err",  64'(alloc_err),  64'd0);

    // basic pushes, then retire from the middle and a non-last beat
    drive(1, 8'h10, 0, 0, 0, 8'h00);
    drive(1, 8'h21, 0, 0, 0, 8'h00);
    drive(1, 8'h32, 0, 0, 0, 8'h00);
    idle();
    drive(0, 8'h00, 1, 1, 1, 8'h21);
    drive(0, 8'h00, 1, 1, 0, 8'h32);
    drive(0, 8'h00, 1, 0, 1, 8'h32);

    // fill, hold an AR while full, retire entry 0 with the AR still held
    drive(1, 8'h43, 0, 0, 0, 8'h00);
    drive(1, 8'h54, 0, 0, 0, 8'h00);
    drive(1, 8'h65, 0, 0, 0, 8'h00);
    drive(1, 8'h65, 1, 1, 1, 8'h10);
    drive(1, 8'h65, 0, 0, 0, 8'h00);
    idle();
    while (mq.size() > 0) drive(0, 8'h00, 1, 1, 1, mq[0]);

    // empty retire and invalid-ID push
    drive(0, 8'h00, 1, 1, 1, 8'h55);
    idle();
    drive(1, INV, 0, 0, 0, 8'h00);
    idle();

    // duplicates with simultaneous push and pop
    drive(1, 8'h10, 0, 0, 0, 8'h00);
    drive(1, 8'h10, 0, 0, 0, 8'h00);
    drive(1, 8'h43, 1, 1, 1, 8'h10);
    idle();

    // asynchronous reset between edges with three entries
    drive(1, 8'h77, 0, 0, 0, 8'h00);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_count",  64'(count),      64'd0);
    check("async_buffer", 64'(rob_buffer), 64'hFFFF_FFFF);
    check("async_valid",  64'(rob_valid),  64'd0);
    check("async_empty",  64'(empty),      64'd1);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) rid = mq[$urandom_range(0, mq.size() - 1)];
      else rid = pick_id();
      drive($urandom_range(0, 2) != 0, pick_id(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rid);
    end
    idle();

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
